// File: rtl/gshare_pht.sv
// gshare pattern history table: PC^history indexed 2-bit counters with a
// registered prediction and a single-port training update (write-first bypass).
module gshare_pht #(
  parameter int GHR_WIDTH = 5,
  parameter int PC_LSB    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_en,
  input  logic [31:0]          lookup_pc,
  input  logic [GHR_WIDTH-1:0] ghr_in,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_index,
  input  logic                 update_en,
  input  logic [GHR_WIDTH-1:0] update_index,
  input  logic                 update_taken
);

  localparam int ENTRIES = 1 << GHR_WIDTH;

  logic [1:0]           ctr_q [ENTRIES];
  logic [GHR_WIDTH-1:0] idx_p0;
  logic [1:0]           upd_ctr_p0;
  logic [1:0]           lookup_ctr_p0;
  logic                 vld_p1;
  logic                 taken_p1;
  logic [GHR_WIDTH-1:0] idx_p1;
  logic                 unused_pc_bits;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11)
      nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00)
      nxt = ctr - 2'b01;
    return nxt;
  endfunction

  assign unused_pc_bits = ^{lookup_pc[31:PC_LSB+GHR_WIDTH], lookup_pc[PC_LSB-1:0]};

  // Stage p0: hash, counter read, same-index bypass of the pending update
  always_comb begin
    idx_p0        = lookup_pc[PC_LSB +: GHR_WIDTH] ^ ghr_in;
    upd_ctr_p0    = ctr_step(ctr_q[update_index], update_taken);
    lookup_ctr_p0 = ctr_q[idx_p0];
    if (update_en && update_index == idx_p0)
      lookup_ctr_p0 = upd_ctr_p0;
  end

  // Stage p1: counter array write and registered prediction
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      idx_p1   <= '0;
    end else begin
      if (update_en)
        ctr_q[update_index] <= upd_ctr_p0;
      if (lookup_en) begin
        vld_p1   <= 1'b1;
        taken_p1 <= lookup_ctr_p0[1];
        idx_p1   <= idx_p0;
      end
    end
  end

  assign pred_valid = vld_p1;
  assign pred_taken = taken_p1;
  assign pred_index = idx_p1;

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: vector table plus a full-table reset sweep, checked
// through an expected-result queue drained one cycle after each drive.
module tb_gshare_pht;

  logic        clk;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic [4:0]  ghr_in;
  logic        pred_valid;
  logic        pred_taken;
  logic [4:0]  pred_index;
  logic        update_en;
  logic [4:0]  update_index;
  logic        update_taken;

  gshare_pht #(.GHR_WIDTH(5), .PC_LSB(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_en    (lookup_en),
    .lookup_pc    (lookup_pc),
    .ghr_in       (ghr_in),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_index   (pred_index),
    .update_en    (update_en),
    .update_index (update_index),
    .update_taken (update_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        len;
    logic [31:0] pc;
    logic [4:0]  ghr;
    logic        uen;
    logic [4:0]  uidx;
    logic        ut;
    logic        ev;
    logic        et;
    logic [4:0]  ei;
  } vec_t;

  typedef struct {
    int         id;
    logic       v;
    logic       t;
    logic [4:0] i;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   step_id = 0;

  function automatic vec_t mk(logic r, logic le, logic [31:0] pc, logic [4:0] g,
                              logic ue, logic [4:0] ui, logic ut,
                              logic ev, logic et, logic [4:0] ei);
    vec_t v;
    v.rst = r; v.len = le; v.pc = pc; v.ghr = g;
    v.uen = ue; v.uidx = ui; v.ut = ut;
    v.ev = ev; v.et = et; v.ei = ei;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    lookup_en    = v.len;
    lookup_pc    = v.pc;
    ghr_in       = v.ghr;
    update_en    = v.uen;
    update_index = v.uidx;
    update_taken = v.ut;
    e.id = step_id; e.v = v.ev; e.t = v.et; e.i = v.ei;
    sb.push_back(e);
    step_id++;
  endtask

  // Monitor: one expected record per driven cycle, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pred_valid === e.v) passes++;
        else $display("FAIL pred_valid step %0d: got %b expected %b", e.id, pred_valid, e.v);
        checks++;
        if (pred_taken === e.t) passes++;
        else $display("FAIL pred_taken step %0d: got %b expected %b", e.id, pred_taken, e.t);
        checks++;
        if (pred_index === e.i) passes++;
        else $display("FAIL pred_index step %0d: got %h expected %h", e.id, pred_index, e.i);
      end
    end
  end

  initial begin
    int budget;
    rst = 1'b1; lookup_en = 1'b0; lookup_pc = '0; ghr_in = '0;
    update_en = 1'b0; update_index = '0; update_taken = 1'b0;

    // reset, then basic lookup
    tbl.push_back(mk(1, 0, 32'h0,  5'h0, 0, 5'h0, 0,  0, 0, 5'h00));
    tbl.push_back(mk(0, 1, 32'h40, 5'h0, 0, 5'h0, 0,  1, 0, 5'h10));
    // train idx 3 up twice, then step it down
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h3, 1,  1, 0, 5'h10));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h3, 1,  1, 0, 5'h10));
    tbl.push_back(mk(0, 1, 32'hC,  5'h0, 0, 5'h0, 0,  1, 1, 5'h03));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h3, 0,  1, 1, 5'h03));
    tbl.push_back(mk(0, 1, 32'hC,  5'h0, 0, 5'h0, 0,  1, 1, 5'h03));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h3, 0,  1, 1, 5'h03));
    tbl.push_back(mk(0, 1, 32'hC,  5'h0, 0, 5'h0, 0,  1, 0, 5'h03));
    // saturate idx 7 high then one down
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 32'h0, 5'h0, 1, 5'h7, 1,  1, 0, 5'h03));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h7, 0,  1, 0, 5'h03));
    tbl.push_back(mk(0, 1, 32'h1C, 5'h0, 0, 5'h0, 0,  1, 1, 5'h07));
    // saturate idx 8 low then one up
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 32'h0, 5'h0, 1, 5'h8, 0,  1, 1, 5'h07));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h8, 1,  1, 1, 5'h07));
    tbl.push_back(mk(0, 1, 32'h20, 5'h0, 0, 5'h0, 0,  1, 0, 5'h08));
    // hash with history plus same-index write-first bypass
    tbl.push_back(mk(0, 1, 32'h10, 5'h04, 1, 5'h0, 1, 1, 1, 5'h00));
    // update to a different index leaves the looked-up counter alone
    tbl.push_back(mk(0, 1, 32'hC,  5'h0, 1, 5'h0, 1,  1, 0, 5'h03));
    tbl.push_back(mk(0, 1, 32'h1C, 5'h0, 0, 5'h0, 0,  1, 1, 5'h07));
    // stall with moving inputs
    tbl.push_back(mk(0, 0, 32'hFFFFFFFC, 5'h1F, 0, 5'h0, 0, 1, 1, 5'h07));
    tbl.push_back(mk(0, 0, 32'h00000008, 5'h0A, 0, 5'h0, 0, 1, 1, 5'h07));
    tbl.push_back(mk(0, 0, 32'h12345670, 5'h15, 0, 5'h0, 0, 1, 1, 5'h07));
    // train idx 2 to strongly taken, then reset with everything active
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h2, 1,  1, 1, 5'h07));
    tbl.push_back(mk(0, 0, 32'h0,  5'h0, 1, 5'h2, 1,  1, 1, 5'h07));
    tbl.push_back(mk(0, 1, 32'h8,  5'h0, 0, 5'h0, 0,  1, 1, 5'h02));
    tbl.push_back(mk(1, 1, 32'h8,  5'h0, 1, 5'h2, 1,  0, 0, 5'h00));
    tbl.push_back(mk(0, 1, 32'h8,  5'h0, 0, 5'h0, 0,  1, 0, 5'h02));

    foreach (tbl[n]) step(tbl[n]);

    // Hand-written: train idx 0 and 31 up, reset, then sweep every entry
    step(mk(0, 0, 32'h0, 5'h0, 1, 5'h00, 1, 1, 0, 5'h02));
    step(mk(0, 0, 32'h0, 5'h0, 1, 5'h1F, 1, 1, 0, 5'h02));
    step(mk(1, 0, 32'h0, 5'h0, 0, 5'h00, 0, 0, 0, 5'h00));
    for (int k = 0; k < 32; k++) begin
      logic [31:0] pc;
      logic [4:0]  g;
      logic [4:0]  idx;
      g   = 5'(k * 7);
      idx = 5'(k);
      pc  = {25'h0, idx ^ g, 2'b00};
      step(mk(0, 1, pc, g, 0, 5'h0, 0, 1, 0, idx));
    end

    @(negedge clk);
    lookup_en = 1'b0; update_en = 1'b0; rst = 1'b0;
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected results left, required 0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
